// File: rtl/multisim_push_pkg.sv
// rtl/multisim_push_pkg.sv - shared state encoding and default parameters for the push FSM
package multisim_push_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        BACKOFF = 2'd2
    } state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_DEPTH       = 4;
    localparam int DEF_RETRY_DELAY = 3;

endpackage

// File: rtl/multisim_push_fifo.sv
// rtl/multisim_push_fifo.sv - power-of-two word buffer with head-of-queue output
module multisim_push_fifo
    import multisim_push_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;
    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    // Storage is cleared on reset so the head reads as zero while reset is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/multisim_push_fsm.sv
// rtl/multisim_push_fsm.sv - buffered push to a sink with retry backoff; MULTISIM_PUSH_STATS_EN adds counters
module multisim_push_fsm
    import multisim_push_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int RETRY_DELAY = DEF_RETRY_DELAY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             data_vld,
    input  logic [WIDTH-1:0] data,
    output logic             data_rdy,
    output logic             push_vld,
    output logic [WIDTH-1:0] push_data,
`ifdef MULTISIM_PUSH_STATS_EN
    output logic [15:0]      push_count,
    output logic [15:0]      retry_count,
`endif
    input  logic             push_ack
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = (RETRY_DELAY > 2) ? $clog2(RETRY_DELAY) : 1;
    localparam int LOAD = (RETRY_DELAY > 0) ? RETRY_DELAY - 1 : 0;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            full, empty, wr, rd;
    logic [AW:0]     count;

    // rst gates data_rdy so nothing is offered upstream while reset is held.
    assign data_rdy = enable & ~full & ~rst;
    assign wr       = data_vld & data_rdy;

    multisim_push_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr      (wr),
        .wr_data (data),
        .rd      (rd),
        .full    (full),
        .empty   (empty),
        .head    (push_data),
        .count   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd       = 1'b0;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !empty) state_d = PUSH;
            end
            PUSH: begin
                push_vld = 1'b1;
                if (push_ack) begin
                    rd = 1'b1;
                    // A word written on the popping edge counts as remaining.
                    if (enable && ((count > (AW+1)'(1)) || wr)) state_d = PUSH;
                    else                                         state_d = IDLE;
                end else if (RETRY_DELAY == 0) begin
                    state_d = PUSH;
                end else begin
                    state_d = BACKOFF;
                    cnt_d   = CW'(LOAD);
                end
            end
            BACKOFF: begin
                if (cnt_q == '0) state_d = PUSH;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MULTISIM_PUSH_STATS_EN
    logic [15:0] push_cnt_q, retry_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_cnt_q  <= '0;
            retry_cnt_q <= '0;
        end else begin
            if (push_vld && push_ack && push_cnt_q != 16'hFFFF)
                push_cnt_q <= push_cnt_q + 16'd1;
            if (push_vld && !push_ack && retry_cnt_q != 16'hFFFF)
                retry_cnt_q <= retry_cnt_q + 16'd1;
        end
    end

    assign push_count  = push_cnt_q;
    assign retry_count = retry_cnt_q;
`endif

endmodule

// File: tb/tb_multisim_push_fsm.sv
// tb/tb_multisim_push_fsm.sv - self-checking bench: vector table, directed corners, random vs queue model
module tb_multisim_push_fsm;

    localparam int D  = 4;
    localparam int RD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0, data_vld = 1'b0, push_ack = 1'b0;
    logic [7:0] data = '0;
    logic       data_rdy, push_vld;
    logic [7:0] push_data;
    logic       z_enable = 1'b0, z_data_vld = 1'b0, z_push_ack = 1'b0;
    logic [7:0] z_data = '0;
    logic       z_data_rdy, z_push_vld;
    logic [7:0] z_push_data;
`ifdef MULTISIM_PUSH_STATS_EN
    logic [15:0] push_count, retry_count, z_push_count, z_retry_count;
`endif

    always #5 clk = ~clk;

    multisim_push_fsm #(.WIDTH(8), .DEPTH(D), .RETRY_DELAY(RD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .data_vld(data_vld), .data(data),
        .data_rdy(data_rdy), .push_vld(push_vld), .push_data(push_data),
`ifdef MULTISIM_PUSH_STATS_EN
        .push_count(push_count), .retry_count(retry_count),
`endif
        .push_ack(push_ack)
    );

    multisim_push_fsm #(.WIDTH(8), .DEPTH(D), .RETRY_DELAY(0)) dut_z (
        .clk(clk), .rst(rst), .enable(z_enable), .data_vld(z_data_vld), .data(z_data),
        .data_rdy(z_data_rdy), .push_vld(z_push_vld), .push_data(z_push_data),
`ifdef MULTISIM_PUSH_STATS_EN
        .push_count(z_push_count), .retry_count(z_retry_count),
`endif
        .push_ack(z_push_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a word queue, a "word in flight" flag and remaining silent cycles.
    logic [7:0] mq[$];
    bit         m_fl;
    int         m_stall;
    int         m_acc, m_rej;

    task automatic model_reset();
        mq.delete();
        m_fl = 0; m_stall = 0; m_acc = 0; m_rej = 0;
    endtask

    function automatic bit m_vld();
        return m_fl && (m_stall == 0);
    endfunction

    function automatic bit m_rdy(input bit en);
        return en && (mq.size() < D);
    endfunction

    task automatic model_edge(input bit en, input bit dv, input logic [7:0] d, input bit ack);
        bit v;
        int pre;
        v   = m_vld();
        pre = mq.size();
        if (dv && m_rdy(en)) mq.push_back(d);
        if (v && ack) begin
            void'(mq.pop_front());
            m_acc++;
            m_fl = en && (mq.size() > 0);
        end else if (v) begin
            m_rej++;
            m_stall = RD;
        end else if (m_fl) begin
            m_stall--;
        end else begin
            m_fl = en && (pre > 0);
        end
    endtask

    typedef struct packed {
        logic       rst, en, dv;
        logic [7:0] d;
        logic       ack, e_rdy, e_vld;
        logic [7:0] e_data;
        logic       chk;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [7:0] d,
                                input logic a, input logic er, input logic ev,
                                input logic [7:0] ed, input logic c);
        vec_t t;
        t.rst = r; t.en = e; t.dv = v; t.d = d; t.ack = a;
        t.e_rdy = er; t.e_vld = ev; t.e_data = ed; t.chk = c;
        return t;
    endfunction

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    vec_t       tv [13];
    logic [7:0] got[$];
    bit         seen;

    initial begin
        // Single word with immediate ack, then a rejected word with 3 silent cycles.
        tv[0]  = mk(1, 1, 0, 8'h00, 1, 0, 0, 8'h00, 1);
        tv[1]  = mk(0, 1, 1, 8'hA5, 1, 1, 0, 8'h00, 0);
        tv[2]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tv[3]  = mk(0, 1, 0, 8'h00, 1, 1, 1, 8'hA5, 1);
        tv[4]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        tv[5]  = mk(0, 1, 1, 8'h3C, 0, 1, 0, 8'h00, 0);
        tv[6]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0);
        tv[7]  = mk(0, 1, 0, 8'h00, 0, 1, 1, 8'h3C, 1);
        tv[8]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h3C, 1);
        tv[9]  = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h3C, 1);
        tv[10] = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h3C, 1);
        tv[11] = mk(0, 1, 0, 8'h00, 1, 1, 1, 8'h3C, 1);
        tv[12] = mk(0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = tv[i].rst; enable = tv[i].en; data_vld = tv[i].dv;
            data = tv[i].d; push_ack = tv[i].ack;
            #1;
            check($sformatf("vec%0d_rdy", i), data_rdy, tv[i].e_rdy);
            check($sformatf("vec%0d_vld", i), push_vld, tv[i].e_vld);
            if (tv[i].chk) check($sformatf("vec%0d_data", i), push_data, tv[i].e_data);
        end

        // Fill to full with the sink stalled, then drain in order.
        pulse_reset();
        enable = 1'b1; push_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            data_vld = 1'b1; data = 8'(i);
            @(negedge clk);
        end
        data = 8'd5;
        #1;
        check("full_rdy", data_rdy, 1'b0);
        @(negedge clk);
        data_vld = 1'b0; push_ack = 1'b1;
        got.delete();
        for (int c = 0; c < 30; c++) begin
            #1;
            if (push_vld) got.push_back(push_data);
            @(negedge clk);
        end
        check("drain_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            check($sformatf("drain_word%0d", i), got[i], i + 1);

        // Reset while backing off with 3 words buffered.
        push_ack = 1'b0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            data_vld = 1'b1; data = 8'h40 + 8'(i);
            @(negedge clk);
        end
        data_vld = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (push_vld) seen = 1;
            @(negedge clk);
        end
        check("bo_reached", seen, 1'b1);
        #1;
        check("bo_vld", push_vld, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_vld", push_vld, 1'b0);
        check("rst_rdy", data_rdy, 1'b0);
        check("rst_data", push_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", data_rdy, 1'b1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            check($sformatf("post_rst_vld%0d", c), push_vld, 1'b0);
        end

        // Zero retry delay: rejection keeps the word presented with no gap.
        pulse_reset();
        z_enable = 1'b1; z_data_vld = 1'b1; z_data = 8'h77; z_push_ack = 1'b0;
        @(negedge clk);
        z_data_vld = 1'b0;
        #1;
        check("z_idle_vld", z_push_vld, 1'b0);
        @(negedge clk); #1;
        check("z_first_vld", z_push_vld, 1'b1);
        check("z_first_data", z_push_data, 8'h77);
        @(negedge clk);
        z_push_ack = 1'b1;
        #1;
        check("z_second_vld", z_push_vld, 1'b1);
        check("z_second_data", z_push_data, 8'h77);
        @(negedge clk);
        z_push_ack = 1'b0;
        #1;
        check("z_after_vld", z_push_vld, 1'b0);

        // Randomized run against the queue model, with occasional resets.
        pulse_reset();
        model_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 199) == 0);
            enable   = ($urandom_range(0, 9) != 0);
            data_vld = $urandom_range(0, 1) != 0;
            data     = 8'($urandom);
            push_ack = ($urandom_range(0, 2) != 0);
            #1;
            if (rst) begin
                model_reset();
                check("rnd_rst_rdy", data_rdy, 1'b0);
                check("rnd_rst_vld", push_vld, 1'b0);
                check("rnd_rst_data", push_data, 8'h00);
            end else begin
                check("rnd_rdy", data_rdy, m_rdy(enable));
                check("rnd_vld", push_vld, m_vld());
                if (m_vld()) check("rnd_data", push_data, mq[0]);
            end
`ifdef MULTISIM_PUSH_STATS_EN
            check("rnd_push_count", push_count, m_acc);
            check("rnd_retry_count", retry_count, m_rej);
`endif
            @(posedge clk);
            if (!rst) model_edge(enable, data_vld, data, push_ack);
        end
        @(negedge clk);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multisim_push_fsm.md
MULTISIM_PUSH_FSM -- requirements
Module: multisim_push_fsm

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: buffer entries; SHALL be a power of two and at least 2.
REQ-003 Parameter RETRY_DELAY, default 3: idle cycles inserted after a rejected push.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  permits new acceptance and new push starts.
REQ-007 data_vld  input  1  upstream word valid.
REQ-008 data  input  WIDTH  upstream word.
REQ-009 data_rdy  output  1  block can accept a word this cycle.
REQ-010 push_vld  output  1  word presented to the sink.
REQ-011 push_data  output  WIDTH  word presented to the sink.
REQ-012 push_ack  input  1  sink accepted push_data this cycle; ignored when push_vld=0.

Function
REQ-013 data_rdy SHALL equal enable AND NOT full; it SHALL have no combinational path from push_ack or data_vld.
REQ-014 A word SHALL be written into the FIFO on an edge where data_vld and data_rdy are both 1.
REQ-015 The FSM SHALL have the states IDLE, PUSH and BACKOFF; push_vld SHALL be 1 only in PUSH.
REQ-016 IDLE->PUSH SHALL occur when enable=1 and the FIFO is non-empty.
REQ-017 push_data SHALL be the FIFO head, and it SHALL stay stable while in PUSH or BACKOFF.
REQ-018 In PUSH with push_ack=1, the head SHALL be popped; the next state SHALL be PUSH if entries remain and enable=1, otherwise IDLE.
REQ-019 In PUSH with push_ack=0, the head SHALL be retained; the next state SHALL be BACKOFF with the counter loaded to RETRY_DELAY-1.
REQ-020 If RETRY_DELAY=0, PUSH with push_ack=0 SHALL stay in PUSH, and the same word SHALL be re-presented the next cycle.
REQ-021 BACKOFF SHALL decrement the counter each cycle and SHALL return to PUSH on the cycle the counter is 0, giving exactly RETRY_DELAY cycles of push_vld=0.
REQ-022 Latency: a word written at edge N into an empty FIFO with FSM in IDLE SHALL appear on push_vld in the cycle after edge N+1.
REQ-023 When full, no write SHALL occur even on a popping cycle; a write and a pop on the same edge SHALL leave the occupancy unchanged.
REQ-024 Pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-025 enable deasserted during PUSH or BACKOFF SHALL NOT abort the word in flight; it SHALL block only the IDLE->PUSH and PUSH->PUSH continuation.

Reset
REQ-026 While rst=1: state=IDLE, occupancy=0, pointers=0, backoff counter=0.
REQ-027 While rst=1: data_rdy=0, push_vld=0 and push_data=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered words and any pending retry immediately.

Configuration
REQ-029 With MULTISIM_PUSH_STATS_EN defined, the block SHALL add outputs push_count[15:0] and retry_count[15:0].
REQ-030 push_count SHALL count accepted pushes; retry_count SHALL count rejected pushes; both SHALL saturate at 16'hFFFF, reset to 0, and be registered.
REQ-031 Without MULTISIM_PUSH_STATS_EN, those ports and counters SHALL be absent, with no other behavioural difference.

Structure
REQ-032 Package multisim_push_pkg SHALL hold the state enum (IDLE, PUSH, BACKOFF) and the default constants for WIDTH, DEPTH and RETRY_DELAY.
REQ-033 The buffer SHALL be a sub-module multisim_push_fifo (WIDTH, DEPTH; wr, rd, full, empty, head); the FSM and backoff counter SHALL be in the top.

Verification
REQ-034 Single word 8'hA5 at edge 0, push_ack tied 1 -> push_vld=1 with push_data=8'hA5 for exactly one cycle after edge 1; FIFO then empty and state IDLE.
REQ-035 Four words 1,2,3,4 with push_ack=0 -> data_rdy=0 after the 4th write; a 5th data_vld is not accepted; release push_ack=1 -> output order 1,2,3,4.
REQ-036 Word 8'h3C with push_ack=0 on first presentation, then 1 -> push_vld low for exactly 3 cycles, then 8'h3C re-presented and popped.
REQ-037 RETRY_DELAY=0 build with push_ack alternating 0,1 -> push_vld held continuously high and the word popped on the second cycle.
REQ-038 rst pulsed while in BACKOFF with 3 words buffered -> push_vld=0 and data_rdy=0 immediately; after release FIFO empty, state IDLE, data_rdy=1 when enable=1.
REQ-039 With MULTISIM_PUSH_STATS_EN defined: 5 accepts and 2 rejects -> push_count=5 and retry_count=2.
